// File: rtl/bilstm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bilstm_pkg
//  Description : Shared types and constants for the BiLSTM sequence scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package bilstm_pkg;

    // Scheduler control states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_CELL  = 3'd2,
        ST_NEXT       = 3'd3,
        ST_WAIT_STORE = 3'd4,
        ST_FINISH     = 3'd5
    } bilstm_sched_state_t;

    // Cell direction encoding
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bilstm_seq_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : bilstm_seq_scheduler_if
//  Description : Control, cell-engine and concat/store signals of the BiLSTM
//                sequence scheduler. master = scheduler, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bilstm_seq_scheduler_if #(
    parameter int SEQ_LEN = 10,
    parameter int DATA_W  = 16
);
    localparam int TS_W = $clog2(SEQ_LEN);

    // layer control
    logic              start;
    logic              busy;
    logic              seq_done;
    logic              err;
    // cell engine
    logic              cell_start;
    logic              cell_dir;
    logic [TS_W-1:0]   cell_timestep;
    logic              cell_state_clear;
    logic              cell_h_valid;
    logic [DATA_W-1:0] cell_h_data;
    logic              cell_done;
    // concat / store
    logic              fwd_valid;
    logic              bwd_valid;
    logic [DATA_W-1:0] forward_out;
    logic [DATA_W-1:0] backward_out;
    logic              bilstm_done;
    logic              store_done;

    modport master (
        input  start, cell_h_valid, cell_h_data, cell_done, store_done,
        output busy, seq_done, err, cell_start, cell_dir, cell_timestep,
               cell_state_clear, fwd_valid, bwd_valid, forward_out,
               backward_out, bilstm_done
    );

    modport slave (
        output start, cell_h_valid, cell_h_data, cell_done, store_done,
        input  busy, seq_done, err, cell_start, cell_dir, cell_timestep,
               cell_state_clear, fwd_valid, bwd_valid, forward_out,
               backward_out, bilstm_done
    );

endinterface
`default_nettype wire

// File: rtl/bilstm_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bilstm_step_sequencer
//  Description : Step counter for the interleaved F0,B(N-1),F1,B(N-2),...
//                order. Maps the step index to direction, timestep,
//                state-clear and end-of-direction / end-of-sequence flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module bilstm_step_sequencer #(
    parameter  int SEQ_LEN = 10,
    localparam int STEP_W  = $clog2(2 * SEQ_LEN),
    localparam int TS_W    = $clog2(SEQ_LEN)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            clear,
    input  wire logic            advance,
    input  wire logic            issue,
    output logic                 cell_dir,
    output logic [TS_W-1:0]      cell_timestep,
    output logic                 cell_state_clear,
    output logic                 dir_final,
    output logic                 last_step
);

    localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(2 * SEQ_LEN - 1);
    localparam logic [TS_W-1:0]   C_LAST_TS   = TS_W'(SEQ_LEN - 1);

    logic [STEP_W-1:0] r_step;
    logic [TS_W-1:0]   w_pair;

    // Step counter: cleared on an accepted start, bumped once per finished step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= '0;
        end else if (clear) begin
            r_step <= '0;
        end else if (advance) begin
            r_step <= r_step + STEP_W'(1);
        end
    end

    // Even steps run forward, odd steps run backward; both walk the same pair index
    always_comb begin
        w_pair           = r_step[STEP_W-1:1];
        cell_dir         = r_step[0];
        cell_timestep    = r_step[0] ? (C_LAST_TS - w_pair) : w_pair;
        cell_state_clear = issue && (w_pair == '0);
        dir_final        = (w_pair == C_LAST_TS);
        last_step        = (r_step == C_LAST_STEP);
    end

endmodule
`default_nettype wire

// File: rtl/bilstm_seq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bilstm_seq_scheduler
//  Description : Time-shares one LSTM cell engine between the forward and
//                backward BiLSTM directions, forwards the final hidden vector
//                of each direction to concat/store and reports completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module bilstm_seq_scheduler
    import bilstm_pkg::*;
#(
    parameter int SEQ_LEN      = 10,
    parameter int HIDDEN_UNITS = 100,
    parameter int DATA_W       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    bilstm_seq_scheduler_if.master bus
);

    localparam int TS_W   = $clog2(SEQ_LEN);
    localparam int BEAT_W = $clog2(HIDDEN_UNITS + 1);
    localparam logic [BEAT_W-1:0] C_BEATS = BEAT_W'(HIDDEN_UNITS);

    bilstm_sched_state_t r_state;
    bilstm_sched_state_t w_next_state;

    logic              w_cell_start;
    logic              w_busy;
    logic              w_bilstm_done;
    logic              w_seq_done;
    logic              w_accept;
    logic              w_advance;

    logic              w_cell_dir;
    logic [TS_W-1:0]   w_cell_timestep;
    logic              w_state_clear;
    logic              w_dir_final;
    logic              w_last_step;

    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_total;
    logic              w_in_cell;
    logic              w_beat_room;
    logic              w_beat_take;
    logic              w_forward;
    logic              w_err_evt;

    logic              r_err;
    logic              r_fwd_valid;
    logic              r_bwd_valid;
    logic [DATA_W-1:0] r_forward_out;
    logic [DATA_W-1:0] r_backward_out;

    bilstm_step_sequencer #(
        .SEQ_LEN (SEQ_LEN)
    ) u_step_seq (
        .clk              (clk),
        .rst              (rst),
        .clear            (w_accept),
        .advance          (w_advance),
        .issue            (w_cell_start),
        .cell_dir         (w_cell_dir),
        .cell_timestep    (w_cell_timestep),
        .cell_state_clear (w_state_clear),
        .dir_final        (w_dir_final),
        .last_step        (w_last_step)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-driven outputs
    always_comb begin
        w_next_state  = r_state;
        w_cell_start  = 1'b0;
        w_busy        = 1'b1;
        w_bilstm_done = 1'b0;
        w_seq_done    = 1'b0;
        w_accept      = 1'b0;
        w_advance     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cell_start = 1'b1;
                w_next_state = ST_WAIT_CELL;
            end
            ST_WAIT_CELL: begin
                if (bus.cell_done) begin
                    w_next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last_step) begin
                    w_next_state = ST_WAIT_STORE;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_WAIT_STORE: begin
                w_bilstm_done = 1'b1;
                if (bus.store_done) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_seq_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Beat accounting and protocol-error detection; the count saturates at
    // HIDDEN_UNITS so surplus beats are flagged and never forwarded
    always_comb begin
        w_in_cell    = (r_state == ST_WAIT_CELL);
        w_beat_room  = (r_beat_cnt != C_BEATS);
        w_beat_take  = w_in_cell && bus.cell_h_valid && w_beat_room;
        w_beat_total = r_beat_cnt + BEAT_W'(w_beat_take);
        w_forward    = w_beat_take && w_dir_final;
        w_err_evt    = (!w_in_cell && (bus.cell_done || bus.cell_h_valid))
                    || ((r_state != ST_WAIT_STORE) && bus.store_done)
                    || (w_in_cell && bus.cell_h_valid && !w_beat_room)
                    || (w_in_cell && bus.cell_done && (w_beat_total != C_BEATS));
    end

    // Beat counter: restarts for every sequence and between steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_accept || (r_state == ST_NEXT)) begin
            r_beat_cnt <= '0;
        end else if (w_beat_take) begin
            r_beat_cnt <= w_beat_total;
        end
    end

    // Sticky error flag; an accepted start opens a clean sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err_evt;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    // One-cycle registered forwarding of the final hidden vector per direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_valid    <= 1'b0;
            r_bwd_valid    <= 1'b0;
            r_forward_out  <= '0;
            r_backward_out <= '0;
        end else begin
            r_fwd_valid <= w_forward && (w_cell_dir == DIR_FWD);
            r_bwd_valid <= w_forward && (w_cell_dir == DIR_BWD);
            if (w_forward && (w_cell_dir == DIR_FWD)) begin
                r_forward_out <= bus.cell_h_data;
            end
            if (w_forward && (w_cell_dir == DIR_BWD)) begin
                r_backward_out <= bus.cell_h_data;
            end
        end
    end

    assign bus.busy             = w_busy;
    assign bus.seq_done         = w_seq_done;
    assign bus.err              = r_err;
    assign bus.cell_start       = w_cell_start;
    assign bus.cell_dir         = w_cell_dir;
    assign bus.cell_timestep    = w_cell_timestep;
    assign bus.cell_state_clear = w_state_clear;
    assign bus.fwd_valid        = r_fwd_valid;
    assign bus.bwd_valid        = r_bwd_valid;
    assign bus.forward_out      = r_forward_out;
    assign bus.backward_out     = r_backward_out;
    assign bus.bilstm_done      = w_bilstm_done;

endmodule
`default_nettype wire

// File: tb/tb_bilstm_seq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bilstm_seq_scheduler
//  Description : Self-checking bench for bilstm_seq_scheduler (N=3, H=4).
//                A bench-side cell model answers each step with random beats;
//                the expected step order and forwarded beats come from the
//                interleaving and forwarding rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bilstm_seq_scheduler;

    localparam int N  = 3;
    localparam int H  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bilstm_seq_scheduler_if #(.SEQ_LEN(N), .DATA_W(DW)) bus ();

    bilstm_seq_scheduler #(
        .SEQ_LEN      (N),
        .HIDDEN_UNITS (H),
        .DATA_W       (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // reference-model state for the step currently being served
    bit m_fwd_step = 1'b0;
    bit m_dir      = 1'b0;
    int m_beats    = 0;
    int n_fwd      = 0;
    int n_bwd      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock; the beat driven this cycle is expected on the
    // direction's output one cycle later if it is among the first H beats of
    // the last step of that direction.
    task automatic clk_step();
        bit            ef;
        bit            eb;
        logic [DW-1:0] ed;
        ef = bus.cell_h_valid && m_fwd_step && !m_dir && (m_beats < H);
        eb = bus.cell_h_valid && m_fwd_step &&  m_dir && (m_beats < H);
        ed = bus.cell_h_data;
        if (bus.cell_h_valid) m_beats++;
        tick();
        bus.start        = 1'b0;
        bus.cell_h_valid = 1'b0;
        bus.cell_done    = 1'b0;
        bus.store_done   = 1'b0;
        chk("fwd_valid", bus.fwd_valid, ef);
        chk("bwd_valid", bus.bwd_valid, eb);
        if (ef) begin
            chk("forward_out", bus.forward_out, ed);
            n_fwd++;
        end
        if (eb) begin
            chk("backward_out", bus.backward_out, ed);
            n_bwd++;
        end
    endtask

    // Serve one cell step: check its launch, then reply with nbeats beats
    task automatic run_step(input int idx, input int nbeats, input bit merge,
                            input bit poke, input int exp_wait);
        int waited;
        int exp_dir;
        int exp_ts;
        waited  = 0;
        exp_dir = idx % 2;
        exp_ts  = (exp_dir == 1) ? (N - 1 - idx / 2) : (idx / 2);
        while (bus.cell_start !== 1'b1 && waited < 16) begin
            clk_step();
            waited++;
        end
        chk("cell_start_latency", waited, exp_wait);
        chk("cell_dir", bus.cell_dir, exp_dir);
        chk("cell_timestep", bus.cell_timestep, exp_ts);
        chk("cell_state_clear", bus.cell_state_clear, (idx < 2) ? 1 : 0);
        m_dir      = exp_dir[0];
        m_fwd_step = (idx / 2 == N - 1);
        m_beats    = 0;
        clk_step();
        chk("cell_start_one_cycle", bus.cell_start, 0);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(0, 2)) clk_step();
            bus.cell_h_valid = 1'b1;
            bus.cell_h_data  = DW'($urandom);
            if (poke && b == 0) bus.start = 1'b1;
            if (merge && b == nbeats - 1) bus.cell_done = 1'b1;
            clk_step();
        end
        if (!merge) begin
            repeat ($urandom_range(0, 2)) clk_step();
            bus.cell_done = 1'b1;
            clk_step();
        end
        m_fwd_step = 1'b0;
        chk("cell_dir_held", bus.cell_dir, exp_dir);
        chk("cell_timestep_held", bus.cell_timestep, exp_ts);
    endtask

    // One complete sequence from start to seq_done
    task automatic run_seq(input int short_step, input int long_step, input bit merge,
                           input bit poke, input int store_delay);
        int nb;
        n_fwd = 0;
        n_bwd = 0;
        bus.start = 1'b1;
        clk_step();
        chk("busy_after_start", bus.busy, 1);
        chk("err_cleared_by_start", bus.err, 0);
        for (int i = 0; i < 2 * N; i++) begin
            nb = H;
            if (i == short_step) nb = H - 1;
            if (i == long_step)  nb = H + 1;
            run_step(i, nb, merge, poke && (i == 2), (i == 0) ? 0 : 1);
            if (i == short_step || i == long_step) chk("err_set", bus.err, 1);
        end
        chk("bilstm_done_not_yet", bus.bilstm_done, 0);
        clk_step();
        chk("bilstm_done_rise", bus.bilstm_done, 1);
        for (int d = 0; d < store_delay; d++) begin
            clk_step();
            chk("bilstm_done_held", bus.bilstm_done, 1);
        end
        chk("seq_done_before_store", bus.seq_done, 0);
        bus.store_done = 1'b1;
        clk_step();
        chk("seq_done_pulse", bus.seq_done, 1);
        chk("bilstm_done_fall", bus.bilstm_done, 0);
        chk("busy_in_finish", bus.busy, 1);
        clk_step();
        chk("busy_low", bus.busy, 0);
        chk("seq_done_single", bus.seq_done, 0);
        chk("fwd_beat_count", n_fwd, H);
        chk("bwd_beat_count", n_bwd, H);
        chk("err_final", bus.err, (short_step >= 0 || long_step >= 0) ? 1 : 0);
    endtask

    initial begin
        int waited;
        bus.start        = 1'b0;
        bus.cell_h_valid = 1'b0;
        bus.cell_h_data  = '0;
        bus.cell_done    = 1'b0;
        bus.store_done   = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_cell_start", bus.cell_start, 0);
        chk("rst_cell_dir", bus.cell_dir, 0);
        chk("rst_cell_timestep", bus.cell_timestep, 0);
        chk("rst_cell_state_clear", bus.cell_state_clear, 0);
        chk("rst_fwd_valid", bus.fwd_valid, 0);
        chk("rst_bwd_valid", bus.bwd_valid, 0);
        chk("rst_forward_out", bus.forward_out, 0);
        chk("rst_backward_out", bus.backward_out, 0);
        chk("rst_bilstm_done", bus.bilstm_done, 0);
        chk("rst_seq_done", bus.seq_done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        repeat (2) clk_step();

        // clean sequence with a long store stall
        run_seq(-1, -1, 1'b0, 1'b0, 20);
        // last beat merged with cell_done on every step, start poked mid-step
        run_seq(-1, -1, 1'b1, 1'b1, 2);
        // a step delivering one beat short
        run_seq(2, -1, 1'b0, 1'b0, 1);
        // the final forward step delivering one beat too many
        run_seq(-1, 4, 1'b0, 1'b0, 0);

        // asynchronous reset while waiting on step 3
        bus.start = 1'b1;
        clk_step();
        for (int i = 0; i < 3; i++) run_step(i, H, 1'b0, 1'b0, (i == 0) ? 0 : 1);
        waited = 0;
        while (bus.cell_start !== 1'b1 && waited < 16) begin
            clk_step();
            waited++;
        end
        chk("step3_start_latency", waited, 1);
        m_dir = 1'b1;
        m_beats = 0;
        clk_step();
        bus.cell_h_valid = 1'b1;
        bus.cell_h_data  = DW'($urandom);
        clk_step();
        chk("step3_timestep_pre_rst", bus.cell_timestep, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_cell_dir", bus.cell_dir, 0);
        chk("arst_cell_timestep", bus.cell_timestep, 0);
        chk("arst_cell_start", bus.cell_start, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_fwd_valid", bus.fwd_valid, 0);
        m_fwd_step = 1'b0;
        m_beats    = 0;
        repeat (2) clk_step();
        rst = 1'b0;
        clk_step();
        run_seq(-1, -1, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bilstm_seq_scheduler.md
# bilstm_seq_scheduler

Sequencer that time-shares one LSTM cell engine between the forward and backward directions of the BiLSTM layer. It runs one sequence per `start`, issuing `2*SEQ_LEN` cell steps in interleaved order F0, B(N-1), F1, B(N-2), …, where N = `SEQ_LEN`. It routes the final hidden vector of each direction to the concat/store stage as `fwd_valid`/`bwd_valid` beats, then holds `bilstm_done` until the store stage reports completion. It sits between the layer-level control FSM and the concat/store block.

## Interface
- `SEQ_LEN`, 10, timesteps per sequence (≥2)
- `HIDDEN_UNITS`, 100, hidden beats per direction per step; equals concat vector_size/2
- `DATA_W`, 16, hidden value width (signed Q-format, passed through untouched)
- `clk` input 1 — clock
- `rst` input 1 — reset, asynchronous, active-high
- `start` input 1 — pulse; begins a sequence; ignored unless idle
- `busy` output 1 — high from accepted `start` through the `seq_done` cycle
- `cell_start` output 1 — one-cycle pulse; launches one cell step
- `cell_dir` output 1 — 0 = forward, 1 = backward; stable from `cell_start` until `cell_done`
- `cell_timestep` output $clog2(SEQ_LEN) — input-sequence index for the step; stable like `cell_dir`
- `cell_state_clear` output 1 — high with `cell_start` on the first step of each direction (F0, B(N-1))
- `cell_h_valid` input 1 — cell emits one hidden beat
- `cell_h_data` input DATA_W — hidden beat value
- `cell_done` input 1 — pulse; current step finished
- `fwd_valid` / `bwd_valid` output 1 — registered beat strobes to concat
- `forward_out` / `backward_out` output DATA_W — registered beat data
- `bilstm_done` output 1 — level; all steps complete, held until `store_done`
- `store_done` input 1 — pulse from concat store stage
- `seq_done` output 1 — one-cycle pulse at end of sequence
- `err` output 1 — sticky protocol error; cleared only by `rst` or an accepted `start`

## Operation
- States: IDLE, ISSUE, WAIT_CELL, NEXT, WAIT_STORE, FINISH.
- IDLE: `start` → ISSUE. Clear the step counter `s` (0..2N-1) and the beat counter. Clear `err`.
- ISSUE: pulse `cell_start`. `cell_dir` = s[0]. `cell_timestep` = s>>1 when forward, N-1-(s>>1) when backward. Go to WAIT_CELL.
- WAIT_CELL: `cell_h_valid` increments the beat counter.
  - Final step of a direction (s = 2N-2 forward, s = 2N-1 backward): forward the beat to `fwd_valid`/`forward_out` or `bwd_valid`/`backward_out` respectively.
  - Other steps: beats are counted but not forwarded.
  - On `cell_done`: if the beat count including a same-cycle beat ≠ HIDDEN_UNITS, set `err`. Go to NEXT.
- NEXT: reset the beat counter. If s = 2N-1 → WAIT_STORE; else s+1 → ISSUE.
- WAIT_STORE: `bilstm_done`=1. On `store_done` → FINISH.
- FINISH: `seq_done`=1 for one cycle, `bilstm_done`=0 → IDLE.
- Protocol errors set `err` and are otherwise ignored:
  - `cell_done` or `cell_h_valid` outside WAIT_CELL.
  - `store_done` outside WAIT_STORE.
  - More than HIDDEN_UNITS beats in a step; extra beats are not forwarded.
- `start` while busy: ignored; no error.
- Counter widths: step counter $clog2(2N) bits; beat counter $clog2(HIDDEN_UNITS+1) bits, saturating.

## Timing
- Reset values: all outputs 0, including `cell_dir`, `cell_timestep` and `err`; state IDLE.
- `start` at cycle c → `cell_start` at c+1.
- `cell_done` at cycle k → next `cell_start` at k+2.
- Forwarded beat latency: exactly one cycle from `cell_h_valid` to `fwd_valid`/`bwd_valid`; order preserved; no backpressure.
- Last step `cell_done` at k → `bilstm_done` rises at k+2. The beat forwarded at k+1 precedes it.
- `store_done` at m → `seq_done` at m+1, `busy` low at m+2. A new `start` is accepted from m+2.
- `rst` mid-operation: immediate return to IDLE; in-flight beats are dropped; the cell engine is expected to be reset by the same `rst`.

## Structure
- Shared package `bilstm_pkg`:
  - state enum `bilstm_sched_state_t`
  - direction constants `DIR_FWD`=0, `DIR_BWD`=1
- One natural sub-module: `bilstm_step_sequencer`. It holds the step counter and maps step → (`cell_dir`, `cell_timestep`, `cell_state_clear`, last-step flag). The FSM and beat routing live in the top.

## Test plan
- N=3, H=4; cell model replies 4 beats then `cell_done`. Required:
  - `(cell_dir, cell_timestep)` order (0,0)(1,2)(0,1)(1,1)(0,2)(1,0).
  - `cell_state_clear` only on the first two steps.
  - Exactly 4 `fwd_valid` (step 4) and 4 `bwd_valid` (step 5), each one cycle after its `cell_h_valid`.
- After the last step, hold `store_done` off for 20 cycles → `bilstm_done` high 20+ cycles; `store_done` → `seq_done` next cycle, `busy` low the cycle after.
- Step returns 3 beats → `err`=1 and the sequence completes. Step returns 5 beats → `err`=1 and only 4 beats are forwarded.
- Fourth beat and `cell_done` in the same cycle → no error; beat forwarded; next `cell_start` 2 cycles later.
- `start` pulsed during WAIT_CELL → ignored; step order unchanged; `err`=0.
- `rst` asserted in WAIT_CELL of step 3 → all outputs 0 asynchronously. New `start` → `cell_start` with (0,0) and `cell_state_clear`=1.
